chay2led_checker: RTL and testbench



---
 rtl/chay2led_checker.sv | 151 +++++++++++++++
 tb/tb_chay2led_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/chay2led_checker.sv
// chay2led_checker: receive-side monitor for the two-LED chaser bus.
// Samples led every clock, locks onto the rotating two-adjacent-LED
// chase, then flags wrong steps and stalls and counts errors.
//
// Ports:
//   clk        system clock, rising edge
//   rs         synchronous active-high reset
//   led[7:0]   observed LED bus
//   locked     high while in LOCK
//   err_pulse  one-cycle pulse per counted error
//   stall      set on stall error, cleared on next led change or reset
//   err_count  errors since reset, saturating at 255
//   pos[2:0]   rotation index of current pattern while locked, else 0
module chay2led_checker #(
  parameter int MAX_HOLD = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [7:0] led,
  output logic       locked,
  output logic       err_pulse,
  output logic       stall,
  output logic [7:0] err_count,
  output logic [2:0] pos
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  state_t         state, state_nx;
  logic [7:0]     led_q;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic [GW-1:0]  good_cnt, good_nx, good_inc;
  logic           locked_nx, err_nx, stall_nx;
  logic [7:0]     errc_nx, errc_inc;
  logic [2:0]     pos_nx;
  logic           chg, good, vld, hold_hit;
  logic [2:0]     kidx;

  // Pattern k: 8'b0000_0011 rotated left by k.
  function automatic logic [7:0] pat(input logic [2:0] k);
    logic [15:0] d;
    d = {8'h03, 8'h03} << k;
    return d[15:8];
  endfunction

  assign chg  = (led != led_q);
  assign good = (led == {led_q[6:0], led_q[7]});

  // Recognise a legal pattern and recover its rotation index.
  always_comb begin
    vld  = 1'b0;
    kidx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (led == pat(k[2:0])) begin
        vld  = 1'b1;
        kidx = k[2:0];
      end
    end
  end

  // hold_hit fires only on the cycle the counter lands on MAX_HOLD, so a
  // frozen bus yields one stall event, not one per cycle.
  assign hold_hit = !chg && (hold_cnt == HW'(MAX_HOLD - 1));
  assign hold_nx  = chg ? '0 :
                    (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
  assign good_inc = good_cnt + 1'b1;
  assign errc_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

  always_comb begin
    state_nx  = state;
    good_nx   = good_cnt;
    pos_nx    = pos;
    err_nx    = 1'b0;
    stall_nx  = stall && !chg;
    errc_nx   = err_count;
    locked_nx = 1'b0;
    case (state)
      HUNT: begin
        if (chg && vld) begin
          state_nx = SYNC;
          good_nx  = '0;
        end
      end
      SYNC: begin
        if (chg) begin
          if (good) begin
            if (good_inc == GW'(LOCK_CNT)) begin
              state_nx = LOCK;
              good_nx  = '0;
              pos_nx   = kidx;
            end else begin
              good_nx  = good_inc;
            end
          end else begin
            state_nx = HUNT;
          end
        end else if (hold_hit) begin
          state_nx = HUNT;
        end
      end
      LOCK: begin
        if (chg) begin
          if (good) begin
            pos_nx = pos + 3'd1;
          end else begin
            err_nx   = 1'b1;
            errc_nx  = errc_inc;
            state_nx = HUNT;
          end
        end else if (hold_hit) begin
          stall_nx = 1'b1;
          err_nx   = 1'b1;
          errc_nx  = errc_inc;
          state_nx = HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
    if (state_nx != LOCK) pos_nx = 3'd0;
    locked_nx = (state_nx == LOCK);
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state     <= HUNT;
      led_q     <= 8'd0;
      hold_cnt  <= '0;
      good_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      stall     <= 1'b0;
      err_count <= 8'd0;
      pos       <= 3'd0;
    end else begin
      state     <= state_nx;
      led_q     <= led;
      hold_cnt  <= hold_nx;
      good_cnt  <= good_nx;
      locked    <= locked_nx;
      err_pulse <= err_nx;
      stall     <= stall_nx;
      err_count <= errc_nx;
      pos       <= pos_nx;
    end
  end

endmodule

// File: tb/tb_chay2led_checker.sv
// Directed-vector bench for chay2led_checker.
module tb_chay2led_checker;

  logic       clk = 1'b0;
  logic       rs;
  logic [7:0] led;
  logic       locked, err_pulse, stall;
  logic [7:0] err_count;
  logic [2:0] pos;

  int nvec = 0;
  int nmis = 0;
  int npulse = 0;

  chay2led_checker #(.MAX_HOLD(16), .LOCK_CNT(4)) dut (
    .clk(clk), .rs(rs), .led(led), .locked(locked), .err_pulse(err_pulse),
    .stall(stall), .err_count(err_count), .pos(pos)
  );

  always #5 clk = ~clk;

  // Pulses observed mid-cycle, away from the active edge.
  always @(negedge clk) if (err_pulse) npulse++;

  task automatic chk(input string tag, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pt(input int k);
    logic [7:0] b;
    b = 8'h03;
    for (int i = 0; i < k % 8; i++) b = {b[6:0], b[7]};
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    led = v;
    repeat (n) tick();
  endtask

  int p0;

  initial begin
    rs  = 1'b1;
    led = 8'd0;
    tick();
    chk("rst_locked", locked, 0);
    chk("rst_pulse",  err_pulse, 0);
    chk("rst_stall",  stall, 0);
    chk("rst_cnt",    err_count, 0);
    chk("rst_pos",    pos, 0);
    rs = 1'b0;

    // Idle bus: nothing to lock to, nothing to flag.
    hold(8'd0, 20);
    chk("idle_locked", locked, 0);
    chk("idle_cnt",    err_count, 0);
    chk("idle_stall",  stall, 0);
    chk("idle_pulses", npulse, 0);

    // Clean chase, 4 cycles per step, 64 steps starting at P(0).
    for (int s = 0; s < 64; s++) begin
      led = pt(s);
      tick();
      if (s == 3) chk("chase_prelock", locked, 0);
      if (s >= 4 && s <= 8) begin
        chk("chase_locked", locked, 1);
        chk("chase_pos", pos, s % 8);
      end
      repeat (3) tick();
    end
    chk("chase_cnt",    err_count, 0);
    chk("chase_pulses", npulse, 0);
    chk("chase_endpos", pos, 7);

    // Jump P(2) -> P(5) while locked.
    hold(pt(0), 4); hold(pt(1), 4); hold(pt(2), 4);
    chk("jump_pos2", pos, 2);
    p0 = npulse;
    led = pt(5);
    tick();
    chk("jump_pulse",  err_pulse, 1);
    chk("jump_cnt",    err_count, 1);
    chk("jump_locked", locked, 0);
    tick();
    chk("jump_pulse_off", err_pulse, 0);
    repeat (2) tick();
    hold(pt(6), 4); hold(pt(7), 4); hold(pt(0), 4); hold(pt(1), 4);
    chk("jump_prelock", locked, 0);
    led = pt(2);
    tick();
    chk("jump_relock", locked, 1);
    chk("jump_relpos", pos, 2);
    repeat (3) tick();
    chk("jump_npulse", npulse - p0, 1);

    // Freeze at P(3) while locked.
    led = pt(3);
    tick();
    chk("frz_pos", pos, 3);
    p0 = npulse;
    repeat (15) tick();
    chk("frz_pre_pulse",  err_pulse, 0);
    chk("frz_pre_stall",  stall, 0);
    chk("frz_pre_locked", locked, 1);
    tick();
    chk("frz_pulse",  err_pulse, 1);
    chk("frz_stall",  stall, 1);
    chk("frz_cnt",    err_count, 2);
    chk("frz_locked", locked, 0);
    repeat (24) tick();
    chk("frz_npulse", npulse - p0, 1);
    chk("frz_stall_hold", stall, 1);
    chk("frz_cnt_hold", err_count, 2);
    led = pt(4);
    tick();
    chk("frz_unstall", stall, 0);
    chk("frz_nolock",  locked, 0);
    repeat (3) tick();
    hold(pt(5), 4); hold(pt(6), 4); hold(pt(7), 4);
    led = pt(0);
    tick();
    chk("frz_relock", locked, 1);
    chk("frz_relpos", pos, 0);
    repeat (3) tick();
    for (int k = 1; k <= 6; k++) hold(pt(k), 4);
    chk("rs_pos6", pos, 6);

    // Reset mid-lock.
    rs = 1'b1;
    tick();
    chk("rs_locked", locked, 0);
    chk("rs_pulse",  err_pulse, 0);
    chk("rs_stall",  stall, 0);
    chk("rs_cnt",    err_count, 0);
    chk("rs_pos",    pos, 0);
    rs = 1'b0;
    // led still P(6): differs from the cleared led_q, so sync restarts here.
    repeat (4) tick();
    hold(pt(7), 4); hold(pt(0), 4); hold(pt(1), 4);
    chk("rs_prelock", locked, 0);
    led = pt(2);
    tick();
    chk("rs_relock", locked, 1);
    chk("rs_relpos", pos, 2);

    // 300 wrong steps (blank bus) with relock in between.
    for (int e = 1; e <= 300; e++) begin
      led = 8'd0;
      tick();
      chk("sat_pulse", err_pulse, 1);
      chk("sat_cnt", err_count, (e > 255) ? 255 : e);
      for (int k = 0; k <= 4; k++) hold(pt(k), 1);
      if (e == 1 || e == 300) chk("sat_relock", locked, 1);
    end
    chk("sat_final", err_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
